// File: rtl/alu_seq_core.sv
// Multi-cycle ALU for the KGP-RISC execute stage: single-cycle add/logic, serial 1-bit/cycle shifter.
// Define ALU_BARREL_SHIFT_EN to replace the serial shifter with a single-cycle barrel shifter (busy tied 0).
module alu_seq_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [6:0]        alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    output logic              sign,
    output logic              branch_taken
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_XOR  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SHLL = 3'b011;
    localparam logic [2:0] OP_SHRL = 3'b100;
    localparam logic [2:0] OP_SHRA = 3'b101;

    state_t              state, state_nxt;
    logic [2:0]          op;
    logic [4:0]          shamt;
    logic [DATA_W-1:0]   a_eff;
    logic [DATA_W:0]     sum;
    logic [DATA_W-1:0]   alu_res;
    logic                alu_cy;
    logic                serial_go;

    // Completion bundle: what gets registered into the outputs when an op finishes
    logic                fin_en;
    logic [DATA_W-1:0]   fin_res;
    logic                fin_cy;
    logic [1:0]          fin_bt;

    assign op    = alu_control[6:4];
    assign shamt = op_b[4:0];
    assign a_eff = alu_control[3] ? ~op_a : op_a;
    assign sum   = {1'b0, a_eff} + {1'b0, op_b} + {{DATA_W{1'b0}}, alu_control[2]};

    function automatic logic br_eval(input logic [1:0] bt, input logic [DATA_W-1:0] r);
        case (bt)
            2'b00:   br_eval = (r == '0);
            2'b01:   br_eval = (r != '0);
            2'b10:   br_eval = r[DATA_W-1];
            default: br_eval = 1'b0;
        endcase
    endfunction

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        case (op)
            OP_AND: alu_res = op_a & op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            OP_ADD: begin
                alu_res = sum[DATA_W-1:0];
                alu_cy  = sum[DATA_W];
            end
`ifdef ALU_BARREL_SHIFT_EN
            OP_SHLL: alu_res = op_a << shamt;
            OP_SHRL: alu_res = op_a >> shamt;
            OP_SHRA: alu_res = $signed(op_a) >>> shamt;
`else
            // Serial build: this path only completes shifts with a zero amount
            OP_SHLL, OP_SHRL, OP_SHRA: alu_res = op_a;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign serial_go = 1'b0;
    assign busy      = 1'b0;
`else
    logic [DATA_W-1:0] acc, acc_shf;
    logic [4:0]        cnt;
    logic [2:0]        op_q;
    logic [1:0]        br_q;
    logic              ld_shift;

    assign serial_go = (op inside {OP_SHLL, OP_SHRL, OP_SHRA}) && (shamt != 5'd0);
    assign busy      = (state == SHIFT);
    assign ld_shift  = (state != SHIFT) && start && serial_go;

    always_comb begin
        case (op_q)
            OP_SHLL: acc_shf = {acc[DATA_W-2:0], 1'b0};
            OP_SHRL: acc_shf = {1'b0, acc[DATA_W-1:1]};
            default: acc_shf = {acc[DATA_W-1], acc[DATA_W-1:1]};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc  <= '0;
            cnt  <= '0;
            op_q <= '0;
            br_q <= '0;
        end else if (ld_shift) begin
            acc  <= op_a;
            cnt  <= shamt;
            op_q <= op;
            br_q <= alu_control[1:0];
        end else if (state == SHIFT) begin
            acc <= acc_shf;
            cnt <= cnt - 5'd1;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        fin_en    = 1'b0;
        fin_res   = alu_res;
        fin_cy    = alu_cy;
        fin_bt    = alu_control[1:0];
        case (state)
            SHIFT: begin
`ifdef ALU_BARREL_SHIFT_EN
                state_nxt = IDLE;
`else
                // Starts arriving here are dropped, not queued
                if (cnt == 5'd1) begin
                    state_nxt = DONE;
                    fin_en    = 1'b1;
                    fin_res   = acc_shf;
                    fin_cy    = 1'b0;
                    fin_bt    = br_q;
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
                if (start) begin
                    if (serial_go) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = DONE;
                        fin_en    = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            carry        <= 1'b0;
            zero         <= 1'b0;
            sign         <= 1'b0;
            branch_taken <= 1'b0;
        end else if (fin_en) begin
            result       <= fin_res;
            carry        <= fin_cy;
            zero         <= (fin_res == '0);
            sign         <= fin_res[DATA_W-1];
            branch_taken <= br_eval(fin_bt, fin_res);
        end
    end

    assign done = (state == DONE);

endmodule

// File: tb/tb_alu_seq_core.sv
// Directed, table-driven bench for alu_seq_core plus hand sequences for handshake and reset corners.
module tb_alu_seq_core;

    logic        clk, rst, start;
    logic [6:0]  alu_control;
    logic [31:0] op_a, op_b;
    logic        busy, done, carry, zero, sign, branch_taken;
    logic [31:0] result;

    int n_tests = 0;
    int n_fail  = 0;

    alu_seq_core #(.DATA_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result),
        .carry(carry), .zero(zero), .sign(sign), .branch_taken(branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        cy;
        logic        z;
        logic        s;
        logic        br;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present an op for exactly one rising edge; returns one time step after that edge
    task automatic issue(input logic [6:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        alu_control = c; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Waits for done; lat counts cycles after the accepting edge, bsy counts busy cycles before done
    task automatic wait_done(output int lat, output int bsy);
        lat = 1; bsy = 0;
        while (!done && lat < 80) begin
            if (busy) bsy++;
            @(posedge clk);
            #1 lat++;
        end
    endtask

    function automatic int shift_lat(input int sh);
`ifdef ALU_BARREL_SHIFT_EN
        shift_lat = 1;
`else
        shift_lat = 1 + sh;
`endif
    endfunction

    vec_t vecs[$];

    initial begin
        int lat, bsy, ndone;
        logic [31:0] held;

        vecs.push_back('{7'b0100011, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{7'b0101111, 32'h5,         32'h0,         32'hFFFF_FFFB, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{7'b0100011, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{7'b0100000, 32'h0,         32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1});
        vecs.push_back('{7'b0100001, 32'h3,         32'h0,         32'h3,         1'b0, 1'b0, 1'b0, 1'b1, 1});
        vecs.push_back('{7'b0100010, 32'h8000_0000, 32'h0,         32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1, 1});
        vecs.push_back('{7'b0100010, 32'h1,         32'h0,         32'h1,         1'b0, 1'b0, 1'b0, 1'b0, 1});
        vecs.push_back('{7'b0100001, 32'h8000_0000, 32'h8000_0000, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 1});
        vecs.push_back('{7'b1010011, 32'h8000_0010, 32'h4,         32'hF800_0001, 1'b0, 1'b0, 1'b1, 1'b0, shift_lat(4)});
        vecs.push_back('{7'b1010011, 32'h8000_0010, 32'h0,         32'h8000_0010, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{7'b0000011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
        vecs.push_back('{7'b0010000, 32'h1234_5678, 32'h1234_5678, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1});
        vecs.push_back('{7'b0110011, 32'h3,         32'd31,        32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0, shift_lat(31)});
        vecs.push_back('{7'b1000011, 32'h8000_0000, 32'd31,        32'h1,         1'b0, 1'b0, 1'b0, 1'b0, shift_lat(31)});
        vecs.push_back('{7'b1000011, 32'h0000_00F0, 32'h24,        32'h0000_000F, 1'b0, 1'b0, 1'b0, 1'b0, shift_lat(4)});
        vecs.push_back('{7'b0110001, 32'h1,         32'h1,         32'h2,         1'b0, 1'b0, 1'b0, 1'b1, shift_lat(1)});
        vecs.push_back('{7'b1100000, 32'h5,         32'h5,         32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 1});
        vecs.push_back('{7'b1110001, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 1});

        rst = 1'b0; start = 1'b0; alu_control = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",  {31'b0, busy}, 32'h0);
        check("reset_done",  {31'b0, done}, 32'h0);
        check("reset_result", result, 32'h0);
        check("reset_flags", {28'b0, carry, zero, sign, branch_taken}, 32'h0);
        @(negedge clk) rst = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].ctrl, vecs[i].a, vecs[i].b);
            wait_done(lat, bsy);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bsy, vecs[i].lat - 1);
            check($sformatf("v%0d_busy_at_done", i), {31'b0, busy}, 32'h0);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flags", i), {28'b0, carry, zero, sign, branch_taken},
                  {28'b0, vecs[i].cy, vecs[i].z, vecs[i].s, vecs[i].br});
            @(posedge clk); #1;
            check($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'h0);
            check($sformatf("v%0d_hold", i), result, vecs[i].res);
        end

`ifndef ALU_BARREL_SHIFT_EN
        // Start pulsed mid-shift must be dropped: one done, shift result intact
        issue(7'b1010011, 32'h8000_0010, 32'h4);
        @(negedge clk);
        alu_control = 7'b0000011; op_a = 32'h0; op_b = 32'h0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0; held = 32'h0;
        for (int c = 0; c < 10; c++) begin
            if (done) begin ndone++; held = result; end
            @(posedge clk); #1;
        end
        check("shift_ignore_start_dones", ndone, 1);
        check("shift_ignore_start_result", held, 32'hF800_0001);
        check("shift_ignore_start_final", result, 32'hF800_0001);
`endif

        // Back-to-back: second start held through the DONE cycle
        issue(7'b0000011, 32'h0000_000F, 32'h0000_0003);
        alu_control = 7'b0000011; op_a = 32'h0000_00FF; op_b = 32'h0000_00F0; start = 1'b1;
        check("b2b_done1", {31'b0, done}, 32'h1);
        check("b2b_res1", result, 32'h3);
        @(posedge clk);
        #1 start = 1'b0;
        check("b2b_done2", {31'b0, done}, 32'h1);
        check("b2b_res2", result, 32'hF0);
        @(posedge clk); #1;
        check("b2b_done_clear", {31'b0, done}, 32'h0);

        // Reset during a long shift discards it
        issue(7'b0110011, 32'h1, 32'd31);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'b0, busy}, 32'h0);
        check("rst_mid_done", {31'b0, done}, 32'h0);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_flags", {28'b0, carry, zero, sign, branch_taken}, 32'h0);
        @(negedge clk) rst = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("rst_mid_no_done", ndone, 0);
        issue(7'b0010011, 32'hF0F0_F0F0, 32'hFFFF_0000);
        wait_done(lat, bsy);
        check("post_rst_xor_latency", lat, 1);
        check("post_rst_xor_result", result, 32'h0F0F_F0F0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
